// File: rtl/rst_seq_pkg.sv
// Shared definitions for the staged reset sequencer: state encoding,
// default parameter values and the counter sizing helpers.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        DONE      = 2'd3
    } state_e;

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_HOLD      = 2'd1;
    localparam logic [1:0] ST_RELEASE   = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    localparam int DEF_NUM_STAGES  = 4;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_STAGE_GAP   = 8;

    // Wide enough to hold the larger of the two delays without wrapping.
    function automatic int cnt_width(input int hold_cycles, input int stage_gap);
        int max_v;
        max_v = (hold_cycles > stage_gap) ? hold_cycles : stage_gap;
        return $clog2(max_v + 1);
    endfunction

    function automatic int idx_width(input int num_stages);
        return $clog2(num_stages + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Releases a bank of active-low block resets one by one once lock is stable,
// re-asserting all of them on lock loss or on an accepted software request.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES  = DEF_NUM_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int STAGE_GAP   = DEF_STAGE_GAP
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  lock_in,
    input  logic                  soft_rst_req,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  seq_done,
    output logic                  lock_lost,
    output logic [1:0]            state_dbg_o
);

    localparam int CW = cnt_width(HOLD_CYCLES, STAGE_GAP);
    localparam int IW = idx_width(NUM_STAGES);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_STAGES - 1);

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  done_q, done_d;
    logic                  lost_q, lost_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        done_d  = done_q;
        lost_d  = lost_q;

        // Lock loss outside WAIT_LOCK overrides everything, including soft requests.
        if (state_q != ST_WAIT_LOCK && !lock_in) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            idx_d   = '0;
            stage_d = '0;
            done_d  = 1'b0;
            lost_d  = 1'b1;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (lock_in) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        stage_d = stage_q | NUM_STAGES'(1);
                        cnt_d   = '0;
                        if (NUM_STAGES == 1) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                            idx_d   = IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        stage_d = stage_q | (NUM_STAGES'(1) << idx_q);
                        cnt_d   = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    // The accepting edge becomes the new lock-qualification edge.
                    if (soft_rst_req) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                        idx_d   = '0;
                        stage_d = '0;
                        done_d  = 1'b0;
                        lost_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    stage_d = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            done_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            done_q  <= done_d;
            lost_q  <= lost_d;
        end
    end

    assign stage_rst_n = stage_q;
    assign seq_done    = done_q;
    assign lock_lost   = lost_q;
    assign state_dbg_o = state_q;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Consumes the synchronized active-low reset (reset_n) from the reset synchronizer and releases a bank of downstream block resets in a fixed, staged order. Each stage is released only after a clock-lock qualifier is stable and a programmable hold-off and inter-stage gap have elapsed. The block sits between the reset synchronizer and every functional block in the clk domain. It also supports a software-requested re-sequence and re-asserts all resets on loss of lock.

Parameters:
NUM_STAGES, 4, number of staged reset outputs; legal range 1..16.
HOLD_CYCLES, 16, cycles from lock qualification to release of stage 0; must be >= 1.
STAGE_GAP, 8, cycles between successive stage releases; must be >= 1.

Ports:
clk  input  1  system clock.
reset_n  input  1  asynchronous active-low reset, fed from the reset synchronizer.
lock_in  input  1  clock/PLL lock qualifier; synchronous to clk (caller guarantees).
soft_rst_req  input  1  single-cycle request to re-run the sequence.
stage_rst_n  output  NUM_STAGES  active-low resets to downstream blocks; bit k is released k-th.
seq_done  output  1  high once all stages are released.
lock_lost  output  1  sticky flag: lock dropped after qualification.

Behaviour:
- Reset (reset_n=0, asynchronous): stage_rst_n=all 0, seq_done=0, lock_lost=0, state=WAIT_LOCK, counters=0. All outputs are registered.
- States: WAIT_LOCK, HOLD, RELEASE, DONE.
- WAIT_LOCK: at the first edge E0 where lock_in=1, go to HOLD and clear the counter.
- HOLD: count cycles. stage_rst_n[0] rises after edge E0+HOLD_CYCLES; then go to RELEASE with stage index=1.
- RELEASE: stage_rst_n[k] rises after edge E0+HOLD_CYCLES+k*STAGE_GAP. Released bits stay high. Bits are never released out of order.
- Last-stage release: seq_done rises on the same edge as stage_rst_n[NUM_STAGES-1], and the state goes to DONE.
- NUM_STAGES=1: release stage 0 and set seq_done on the same edge, going HOLD->DONE directly.
- Lock loss: lock_in=0 sampled in HOLD, RELEASE or DONE. On that edge: stage_rst_n=all 0, seq_done=0, lock_lost=1, state=WAIT_LOCK, counters cleared. Lock loss has priority over soft_rst_req.
- Soft request: soft_rst_req=1 in DONE with lock_in=1. On that edge: stage_rst_n=all 0, seq_done=0, lock_lost=0, state=HOLD, counter cleared. That edge acts as the new E0.
- soft_rst_req in WAIT_LOCK, HOLD or RELEASE is ignored (no queuing).
- lock_lost clears only on reset_n or an accepted soft_rst_req.
- Glitch rule: stage_rst_n bits change only at clk edges or on async reset. No combinational path from any input to any output.
- Counter width: $clog2(max(HOLD_CYCLES,STAGE_GAP)+1). Stage index width: $clog2(NUM_STAGES+1). No wrap-around is possible within a sequence.

Decomposition:
- Shared package (rst_seq_pkg):
  - state enum {WAIT_LOCK, HOLD, RELEASE, DONE};
  - default parameter constants;
  - a function computing counter width.
- No sub-module is required. The FSM, cycle counter and stage index fit in one module.

Test Plan:
- Defaults, reset_n released, lock_in=1 from E0 -> stage_rst_n: 0000 -> 0001 after E0+16, 0011 at +24, 0111 at +32, 1111 at +40; seq_done=1 at +40; lock_lost=0.
- lock_in held 0 for 100 cycles after reset -> stage_rst_n=0000, seq_done=0 throughout; sequence starts only when lock_in rises.
- lock_in drops at E0+28 (stages 0,1 released) -> next edge: stage_rst_n=0000, lock_lost=1. lock_in back at edge E1 -> stage0 after E1+16; lock_lost stays 1.
- In DONE, pulse soft_rst_req at edge S -> stage_rst_n=0000, seq_done=0, lock_lost=0 at S; full release again ending at S+40. A soft_rst_req pulse during RELEASE is ignored, with timing unchanged.
- reset_n asserted mid-RELEASE (stage_rst_n=0011) -> immediate asynchronous stage_rst_n=0000, seq_done=0, lock_lost=0, independent of clk.
- Corner parameters NUM_STAGES=1, HOLD_CYCLES=1, STAGE_GAP=1 -> stage_rst_n[0] and seq_done rise after E0+1. Also NUM_STAGES=3, STAGE_GAP=1 -> stages released on consecutive edges.
